// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1/2 stop bits, 3-sample vote.
// Define UART_RX_BREAK_EN to suppress all-zero frames and flag them on break_det instead.
module uart_rx_ext #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [15:0]          baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic                 break_det
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_VLO  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_VMID = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_VHI  = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]     BITS_N  = 4'(DATA_BITS);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e                 state_q;
  logic [1:0]             sync_q;
  logic [15:0]            div_q, pre_q;
  logic [OSW-1:0]         os_q;
  logic [1:0]             smp_q;
  logic [3:0]             bit_q;
  logic                   stop_q;
  logic [DATA_BITS-1:0]   sh_q, rx_data_q;
  logic                   perr_q, ferr_q;
  logic                   rx_valid_q, frame_err_q, parity_err_q, overrun_q;
`ifdef UART_RX_BREAK_EN
  logic                   zero_q, brk_q;
  logic [OSW-1:0]         hi_q;
`endif

  logic s, tick, bound, vote_t, vote, par_exp, frame_bad;

  assign s         = sync_q[1];
  assign tick      = (state_q != IDLE) && (pre_q == div_q);
  assign bound     = tick && (os_q == OS_LAST);
  assign vote_t    = tick && (os_q == OS_VHI);
  assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);
  assign par_exp   = (^sh_q) ^ PAR_ODD;
  assign frame_bad = ferr_q | ~vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      div_q        <= '0;
      pre_q        <= '0;
      os_q         <= '0;
      smp_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q       <= 1'b0;
      brk_q        <= 1'b0;
      hi_q         <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rxd};
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (state_q != IDLE) begin
        if (tick) begin
          pre_q <= '0;
          os_q  <= os_q + OSW'(1);
        end else begin
          pre_q <= pre_q + 16'd1;
        end
      end
      if (tick && os_q == OS_VLO) smp_q[0] <= s;
      if (tick && os_q == OS_VMID) smp_q[1] <= s;

      case (state_q)
        IDLE: if (!s) begin
          state_q <= START;
          pre_q   <= '0;
          os_q    <= '0;
          div_q   <= baud_div;
        end
        START: begin
          if (vote_t && vote) begin
            state_q <= IDLE;
          end else if (bound) begin
            state_q <= DATA;
            bit_q   <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_q  <= 1'b1;
`endif
          end
        end
        DATA: begin
          if (vote_t) begin
            sh_q  <= {vote, sh_q[DATA_BITS-1:1]};
            bit_q <= bit_q + 4'd1;
`ifdef UART_RX_BREAK_EN
            zero_q <= zero_q & ~vote;
`endif
          end
          if (bound && bit_q == BITS_N) begin
            state_q <= (PARITY != 0) ? PAR : STOP;
            stop_q  <= 1'b0;
          end
        end
        PAR: begin
          if (vote_t) begin
            perr_q <= vote ^ par_exp;
`ifdef UART_RX_BREAK_EN
            zero_q <= zero_q & ~vote;
`endif
          end
          if (bound) begin
            state_q <= STOP;
            stop_q  <= 1'b0;
          end
        end
        STOP: begin
`ifdef UART_RX_BREAK_EN
          // Break hold: leave only after a full bit time of continuous idle line.
          if (brk_q) begin
            if (!s) begin
              hi_q <= '0;
            end else if (tick) begin
              if (hi_q == OS_LAST) begin
                brk_q   <= 1'b0;
                state_q <= IDLE;
              end else begin
                hi_q <= hi_q + OSW'(1);
              end
            end
          end else
`endif
          if (vote_t) begin
            if (!vote) ferr_q <= 1'b1;
            if (stop_q == STOP_LAST) begin
`ifdef UART_RX_BREAK_EN
              if (zero_q && !vote) begin
                brk_q <= 1'b1;
                hi_q  <= '0;
              end else
`endif
              begin
                // Deliver at the last stop vote so a short stop bit still resyncs.
                state_q <= IDLE;
                if (!rx_valid_q || rx_ready) begin
                  rx_data_q    <= sh_q;
                  frame_err_q  <= frame_bad;
                  parity_err_q <= perr_q;
                  rx_valid_q   <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end else begin
              stop_q <= 1'b1;
`ifdef UART_RX_BREAK_EN
              zero_q <= zero_q & ~vote;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_BREAK_EN
  assign break_det  = brk_q;
`else
  assign break_det  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 8E1 and 8N2 instances on separate lines, 64 clk per bit.
module tb_uart_rx_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic [15:0] baud_div;
  logic [2:0] rxd_v;
  logic [2:0] rdy_v;
  logic [7:0] rx_data_v [3];
  logic       rx_valid_v [3];
  logic       ferr_v [3];
  logic       perr_v [3];
  logic       ovr_v [3];
  logic       busy_v [3];
  logic       brk_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] last_data [3];
  logic       last_fe [3];
  logic       last_pe [3];
  int         nwords [3];
  int         vhigh [3];
  int         novr [3];
  int         w, v, o;

  always #5 clk = ~clk;

  uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .baud_div(baud_div),
    .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]), .rx_ready(rdy_v[0]),
    .frame_err(ferr_v[0]), .parity_err(perr_v[0]), .overrun(ovr_v[0]),
    .busy(busy_v[0]), .break_det(brk_v[0]));

  uart_rx_ext #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .baud_div(baud_div),
    .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]), .rx_ready(rdy_v[1]),
    .frame_err(ferr_v[1]), .parity_err(perr_v[1]), .overrun(ovr_v[1]),
    .busy(busy_v[1]), .break_det(brk_v[1]));

  uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_8n2 (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .baud_div(baud_div),
    .rx_data(rx_data_v[2]), .rx_valid(rx_valid_v[2]), .rx_ready(rdy_v[2]),
    .frame_err(ferr_v[2]), .parity_err(perr_v[2]), .overrun(ovr_v[2]),
    .busy(busy_v[2]), .break_det(brk_v[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid_v[i] === 1'b1) vhigh[i] <= vhigh[i] + 1;
      if (ovr_v[i] === 1'b1) novr[i] <= novr[i] + 1;
      if (rx_valid_v[i] === 1'b1 && rdy_v[i] === 1'b1) begin
        nwords[i]    <= nwords[i] + 1;
        last_data[i] <= rx_data_v[i];
        last_fe[i]   <= ferr_v[i];
        last_pe[i]   <= perr_v[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits LSB first, one bit per 64 clk; line returns high afterwards.
  task automatic send_frame(input int lane, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_v[lane] = bits[i];
      repeat (64) @(negedge clk);
    end
    rxd_v[lane] = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    rxd_v    = '1;
    rdy_v    = '1;
    baud_div = 16'd3;
    idle(4);
    for (int i = 0; i < 3; i++) begin
      check("rst_data",  32'(rx_data_v[i]), 32'h0);
      check("rst_valid", 32'(rx_valid_v[i]), 32'h0);
      check("rst_ferr",  32'(ferr_v[i]), 32'h0);
      check("rst_perr",  32'(perr_v[i]), 32'h0);
      check("rst_ovr",   32'(ovr_v[i]), 32'h0);
      check("rst_busy",  32'(busy_v[i]), 32'h0);
      check("rst_brk",   32'(brk_v[i]), 32'h0);
    end
    rst = 1'b0;
    idle(20);

    w = nwords[0]; v = vhigh[0];
    send_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    idle(40);
    check("t1_words", 32'(nwords[0] - w), 32'd1);
    check("t1_vcyc",  32'(vhigh[0] - v), 32'd1);
    check("t1_data",  32'(last_data[0]), 32'hA5);
    check("t1_ferr",  32'(last_fe[0]), 32'h0);
    check("t1_perr",  32'(last_pe[0]), 32'h0);
    check("t1_busy",  32'(busy_v[0]), 32'h0);

    w = nwords[1];
    send_frame(1, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(40);
    check("t2_words_a", 32'(nwords[1] - w), 32'd1);
    check("t2_data_a",  32'(last_data[1]), 32'h3C);
    check("t2_perr_a",  32'(last_pe[1]), 32'h1);
    check("t2_ferr_a",  32'(last_fe[1]), 32'h0);
    send_frame(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    idle(40);
    check("t2_words_b", 32'(nwords[1] - w), 32'd2);
    check("t2_data_b",  32'(last_data[1]), 32'h3C);
    check("t2_perr_b",  32'(last_pe[1]), 32'h0);

    w = nwords[2];
    send_frame(2, {5'b0, 1'b0, 1'b1, 8'h96, 1'b0}, 11);
    idle(40);
    check("t3_words_a", 32'(nwords[2] - w), 32'd1);
    check("t3_data_a",  32'(last_data[2]), 32'h96);
    check("t3_ferr_a",  32'(last_fe[2]), 32'h1);
    send_frame(2, {5'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
    idle(40);
    check("t3_words_b", 32'(nwords[2] - w), 32'd2);
    check("t3_data_b",  32'(last_data[2]), 32'h55);
    check("t3_ferr_b",  32'(last_fe[2]), 32'h0);

    w = nwords[0];
    rxd_v[0] = 1'b0;
    idle(16);
    rxd_v[0] = 1'b1;
    idle(8);
    check("t4_busy_glitch", 32'(busy_v[0]), 32'h1);
    idle(60);
    check("t4_idle",     32'(busy_v[0]), 32'h0);
    check("t4_no_word",  32'(nwords[0] - w), 32'd0);
    send_frame(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
    idle(40);
    check("t4_words", 32'(nwords[0] - w), 32'd1);
    check("t4_data",  32'(last_data[0]), 32'h81);
    check("t4_ferr",  32'(last_fe[0]), 32'h0);

    rdy_v[0] = 1'b0;
    w = nwords[0]; o = novr[0];
    send_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    idle(40);
    check("t5_held_valid", 32'(rx_valid_v[0]), 32'h1);
    check("t5_held_data",  32'(rx_data_v[0]), 32'h11);
    check("t5_ovr_cycles", 32'(novr[0] - o), 32'd1);
    @(posedge clk);
    #1 rdy_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_drop", 32'(rx_valid_v[0]), 32'h0);
    check("t5_words",      32'(nwords[0] - w), 32'd1);
    check("t5_data",       32'(last_data[0]), 32'h11);

    rdy_v[0] = 1'b0;
    send_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    idle(40);
    check("t6_pending", 32'(rx_valid_v[0]), 32'h1);
    send_frame(0, {6'b0, 1'b1, 8'hF0, 1'b0}, 4);
    check("t6_busy_mid", 32'(busy_v[0]), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(rx_valid_v[0]), 32'h0);
    check("t6_rst_data",  32'(rx_data_v[0]), 32'h0);
    check("t6_rst_busy",  32'(busy_v[0]), 32'h0);
    check("t6_rst_ferr",  32'(ferr_v[0]), 32'h0);
    idle(3);
    rst = 1'b0;
    rdy_v[0] = 1'b1;
    w = nwords[0];
    idle(20);
    send_frame(0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10);
    idle(40);
    check("t6_words", 32'(nwords[0] - w), 32'd1);
    check("t6_data",  32'(last_data[0]), 32'h0F);
    check("t6_ferr",  32'(last_fe[0]), 32'h0);

    w = nwords[0]; o = novr[0];
`ifdef UART_RX_BREAK_EN
    rxd_v[0] = 1'b0;
    idle(704);
    check("t7_brk_set",   32'(brk_v[0]), 32'h1);
    check("t7_brk_novld", 32'(rx_valid_v[0]), 32'h0);
    idle(64);
    rxd_v[0] = 1'b1;
    idle(80);
    check("t7_brk_clr",   32'(brk_v[0]), 32'h0);
    check("t7_brk_idle",  32'(busy_v[0]), 32'h0);
    check("t7_brk_words", 32'(nwords[0] - w), 32'd0);
    check("t7_brk_ovr",   32'(novr[0] - o), 32'd0);
`else
    rxd_v[0] = 1'b0;
    idle(624);
    rxd_v[0] = 1'b1;
    idle(200);
    check("t7_zero_words", 32'(nwords[0] - w), 32'd1);
    check("t7_zero_data",  32'(last_data[0]), 32'h0);
    check("t7_zero_ferr",  32'(last_fe[0]), 32'h1);
    check("t7_zero_brk",   32'(brk_v[0]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
